// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage hazard scheduler (forwarding, load-use stall,
// redirect flush, ebreak halt).
// Ports: clk, rstn (sync, active-low); id_* consumer in ID/EX;
//   ex_* EX/MEM producer; wb_* MEM/WB producer; redirect_req.
//   Out: fwd_en_1/2, fwd_data_rs1/2, stall, flush_nop, flush_id, halted.
// Optional: `define HAZARD_PERF_EN adds perf_stall_cnt, perf_flush_cnt.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_wb_en,
   input  logic        ex_load_en,
   input  logic        ex_wb_spc_en,
   input  logic [63:0] ex_alu_result,
   input  logic [63:0] ex_snxt_pc,
   input  logic        ex_ebreak_en,
   input  logic        redirect_req,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        wb_wb_en,
   input  logic [63:0] wb_data,
   output logic        fwd_en_1,
   output logic        fwd_en_2,
   output logic [63:0] fwd_data_rs1,
   output logic [63:0] fwd_data_rs2,
   output logic        stall,
   output logic        flush_nop,
   output logic        flush_id,
   output logic        halted
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN, LD_WAIT, FLUSH, HALT
   } state_t;

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
   // With a single bubble the redirect cycle itself is the whole flush.
   localparam state_t FL_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t     state;
   logic [2:0] cnt;

   logic        active;
   logic        ex_m1, ex_m2, wb_m1, wb_m2;
   logic        load_use, halt_go;
   logic [63:0] ex_data;

   assign active = (state == RUN) || (state == LD_WAIT);

   assign ex_m1 = id_rs1_used && (id_rs1 != 5'd0) && ex_valid
                  && ex_wb_en && (ex_rd == id_rs1);
   assign ex_m2 = id_rs2_used && (id_rs2 != 5'd0) && ex_valid
                  && ex_wb_en && (ex_rd == id_rs2);
   assign wb_m1 = id_rs1_used && (id_rs1 != 5'd0) && wb_valid
                  && wb_wb_en && (wb_rd == id_rs1);
   assign wb_m2 = id_rs2_used && (id_rs2 != 5'd0) && wb_valid
                  && wb_wb_en && (wb_rd == id_rs2);

   assign ex_data  = ex_wb_spc_en ? ex_snxt_pc : ex_alu_result;
   assign load_use = (state == RUN) && id_valid && ex_load_en
                     && (ex_m1 || ex_m2);
   assign halt_go  = ex_valid && ex_ebreak_en && (state != HALT);

   always_comb begin
      fwd_en_1     = 1'b0;
      fwd_en_2     = 1'b0;
      fwd_data_rs1 = 64'd0;
      fwd_data_rs2 = 64'd0;
      stall        = 1'b0;
      flush_nop    = 1'b0;
      flush_id     = 1'b0;
      halted       = 1'b0;
      if (rstn) begin
         unique case (state)
            HALT: begin
               stall     = 1'b1;
               flush_nop = 1'b1;
               halted    = 1'b1;
            end
            FLUSH: begin
               flush_id  = 1'b1;
               flush_nop = 1'b1;
            end
            default: begin
               if (redirect_req) begin
                  flush_id  = 1'b1;
                  flush_nop = 1'b1;
               end else if (load_use) begin
                  stall     = 1'b1;
                  flush_nop = 1'b1;
               end
            end
         endcase
         // A load in EX/MEM has no data yet: block it rather than
         // falling back to an older WB value.
         if (active && id_valid) begin
            if (ex_m1 && !ex_load_en) begin
               fwd_en_1     = 1'b1;
               fwd_data_rs1 = ex_data;
            end else if (!ex_m1 && wb_m1) begin
               fwd_en_1     = 1'b1;
               fwd_data_rs1 = wb_data;
            end
            if (ex_m2 && !ex_load_en) begin
               fwd_en_2     = 1'b1;
               fwd_data_rs2 = ex_data;
            end else if (!ex_m2 && wb_m2) begin
               fwd_en_2     = 1'b1;
               fwd_data_rs2 = wb_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else if (halt_go) begin
         state <= HALT;
         cnt   <= 3'd0;
      end else begin
         unique case (state)
            RUN: begin
               if (redirect_req) begin
                  state <= FL_NEXT;
                  cnt   <= CNT_LOAD;
               end else if (load_use) begin
                  state <= LD_WAIT;
               end
            end
            LD_WAIT: begin
               if (redirect_req) begin
                  state <= FL_NEXT;
                  cnt   <= CNT_LOAD;
               end else begin
                  state <= RUN;
               end
            end
            FLUSH: begin
               if (redirect_req) begin
                  state <= FL_NEXT;
                  cnt   <= CNT_LOAD;
               end else if (cnt <= 3'd1) begin
                  state <= RUN;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            HALT: state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (stall && (state != HALT))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush_id)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl.
// Ports: none (drives clk/rstn and all DUT inputs).
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        id_valid, id_rs1_used, id_rs2_used;
   logic [4:0]  id_rs1, id_rs2;
   logic        ex_valid, ex_wb_en, ex_load_en, ex_wb_spc_en;
   logic        ex_ebreak_en, redirect_req;
   logic [4:0]  ex_rd, wb_rd;
   logic [63:0] ex_alu_result, ex_snxt_pc, wb_data;
   logic        wb_valid, wb_wb_en;
   logic        fwd_en_1, fwd_en_2, stall, flush_nop, flush_id, halted;
   logic [63:0] fwd_data_rs1, fwd_data_rs2;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .rstn(rstn),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
      .ex_load_en(ex_load_en), .ex_wb_spc_en(ex_wb_spc_en),
      .ex_alu_result(ex_alu_result), .ex_snxt_pc(ex_snxt_pc),
      .ex_ebreak_en(ex_ebreak_en), .redirect_req(redirect_req),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wb_en(wb_wb_en),
      .wb_data(wb_data),
      .fwd_en_1(fwd_en_1), .fwd_en_2(fwd_en_2),
      .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2),
      .stall(stall), .flush_nop(flush_nop), .flush_id(flush_id),
      .halted(halted)
`ifdef HAZARD_PERF_EN
     ,.perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_valid = 1'b0; ex_rd = 5'd0; ex_wb_en = 1'b0;
      ex_load_en = 1'b0; ex_wb_spc_en = 1'b0;
      ex_alu_result = 64'd0; ex_snxt_pc = 64'd0;
      ex_ebreak_en = 1'b0; redirect_req = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_wb_en = 1'b0;
      wb_data = 64'd0;
   endtask

   // advance to the next negedge, then let inputs settle
   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      clr();
      @(posedge clk);
      @(posedge clk);
      nxt(); #1;
      chk("rst_stall", stall, 0);
      chk("rst_flush_id", flush_id, 0);
      chk("rst_flush_nop", flush_nop, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fwd_en_1", fwd_en_1, 0);
      chk("rst_fwd_data_1", fwd_data_rs1, 0);
`ifdef HAZARD_PERF_EN
      chk("rst_perf_stall", perf_stall_cnt, 0);
      chk("rst_perf_flush", perf_flush_cnt, 0);
`endif
      rstn = 1'b1;

      // 1: EX beats WB
      nxt();
      id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
      ex_valid = 1; ex_rd = 5; ex_wb_en = 1; ex_alu_result = 64'h10;
      wb_valid = 1; wb_rd = 5; wb_wb_en = 1; wb_data = 64'h20;
      #1;
      chk("t1_fwd_en_1", fwd_en_1, 1);
      chk("t1_fwd_data_1", fwd_data_rs1, 64'h10);
      chk("t1_stall", stall, 0);
      ex_wb_en = 0; #1;
      chk("t1_wb_fwd_data_1", fwd_data_rs1, 64'h20);
      id_rs1_used = 0; #1;
      chk("t1_unused_fwd_en_1", fwd_en_1, 0);

      // 2: x0 never forwarded
      nxt(); clr();
      id_valid = 1; id_rs2 = 0; id_rs2_used = 1;
      ex_valid = 1; ex_rd = 0; ex_wb_en = 1; ex_alu_result = 64'h55;
      #1;
      chk("t2_fwd_en_2", fwd_en_2, 0);
      chk("t2_fwd_data_2", fwd_data_rs2, 0);
      chk("t2_stall", stall, 0);

      // 6: jal/jalr result is pc+4
      nxt(); clr();
      id_valid = 1; id_rs1 = 1; id_rs1_used = 1;
      ex_valid = 1; ex_rd = 1; ex_wb_en = 1; ex_wb_spc_en = 1;
      ex_snxt_pc = 64'h80000008; ex_alu_result = 64'h1234;
      #1;
      chk("t6_fwd_en_1", fwd_en_1, 1);
      chk("t6_fwd_data_1", fwd_data_rs1, 64'h80000008);

      // 3: load-use, one-cycle penalty
      nxt(); clr();
      id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
      ex_valid = 1; ex_rd = 7; ex_wb_en = 1; ex_load_en = 1;
      #1;
      chk("t3_stall", stall, 1);
      chk("t3_flush_nop", flush_nop, 1);
      chk("t3_fwd_en_1", fwd_en_1, 0);
      nxt();
      ex_valid = 0; ex_load_en = 0; ex_wb_en = 0;
      wb_valid = 1; wb_rd = 7; wb_wb_en = 1; wb_data = 64'hABCD;
      #1;
      chk("t3_wait_stall", stall, 0);
      chk("t3_wait_flush_nop", flush_nop, 0);
      chk("t3_wait_fwd_en_1", fwd_en_1, 1);
      chk("t3_wait_fwd_data_1", fwd_data_rs1, 64'hABCD);
      nxt(); clr(); #1;
      chk("t3_after_stall", stall, 0);

      // 4: redirect -> exactly 2 flush cycles
      nxt(); redirect_req = 1; #1;
      chk("t4_c0_flush_id", flush_id, 1);
      chk("t4_c0_flush_nop", flush_nop, 1);
      chk("t4_c0_stall", stall, 0);
      nxt(); redirect_req = 0; #1;
      chk("t4_c1_flush_id", flush_id, 1);
      nxt(); #1;
      chk("t4_c2_flush_id", flush_id, 0);
      chk("t4_c2_flush_nop", flush_nop, 0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall", perf_stall_cnt, 1);
      chk("perf_flush", perf_flush_cnt, 2);
`endif

      // 4b: redirect overrides a same-cycle load-use
      nxt();
      id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
      ex_valid = 1; ex_rd = 7; ex_wb_en = 1; ex_load_en = 1;
      redirect_req = 1;
      #1;
      chk("t4b_stall", stall, 0);
      chk("t4b_flush_id", flush_id, 1);
      nxt(); clr(); #1;
      chk("t4b_c1_flush_id", flush_id, 1);
      chk("t4b_c1_stall", stall, 0);
      nxt(); #1;
      chk("t4b_c2_flush_id", flush_id, 0);

      // 4c: redirect during FLUSH reloads the counter
      nxt(); redirect_req = 1; #1;
      nxt(); #1;
      chk("t4c_re_flush_id", flush_id, 1);
      nxt(); redirect_req = 0; #1;
      chk("t4c_c1_flush_id", flush_id, 1);
      nxt(); #1;
      chk("t4c_c2_flush_id", flush_id, 0);

      // 5: ebreak halts from the next cycle until reset
      nxt(); ex_valid = 1; ex_ebreak_en = 1; #1;
      chk("t5_c0_halted", halted, 0);
      nxt(); clr();
      id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
      wb_valid = 1; wb_rd = 3; wb_wb_en = 1; wb_data = 64'h77;
      #1;
      for (int i = 0; i < 12; i++) begin
         chk("t5_halted", halted, 1);
         chk("t5_stall", stall, 1);
         chk("t5_fwd_en_1", fwd_en_1, 0);
         nxt(); #1;
      end
      chk("t5_flush_nop", flush_nop, 1);
      rstn = 0; #1;
      chk("t5_rst_halted", halted, 0);
      nxt(); rstn = 1; #1;
      chk("t5_post_halted", halted, 0);
      chk("t5_post_stall", stall, 0);
      chk("t5_post_fwd_data_1", fwd_data_rs1, 64'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
